// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO registers.
// Multiplication is radix-2 shift-add and division is restoring; each takes WIDTH cycles.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic               signed_op_s, accept_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     mul_sum_s, rem_sh_s, diff_s;
  logic [2*WIDTH-1:0] mul_step_s, mul_res_s, div_step_s;

  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg2(v) : v;
  endfunction

  // Next-state, datapath step and HI/LO update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = 1'b0;

    signed_op_s = ~op[0];
    accept_s    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    mag_a_s     = mag(a, signed_op_s);
    mag_b_s     = mag(b, signed_op_s);

    // Shift-add: the multiplier sits in the low half and is consumed LSB first.
    mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
    mul_step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    mul_res_s  = neg_res_q ? (~mul_step_s + (2*WIDTH)'(1)) : mul_step_s;

    // Restoring step: remainder in the high half, dividend shifts out as quotient bits shift in.
    rem_sh_s   = acc_q[2*WIDTH-1:WIDTH-1];
    diff_s     = rem_sh_s - {1'b0, opnd_q};
    if (diff_s[WIDTH]) begin
      div_step_s = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_step_s = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (hi_we) hi_d = wdata;
        else       hi_d = hi_q;
        if (lo_we) lo_d = wdata;
        else       lo_d = lo_q;
        if (accept_s) begin
          neg_res_d = signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = signed_op_s & a[WIDTH-1];
          cnt_d     = CW'(WIDTH);
          if (op[1] && (b == WIDTH'(0))) begin
            state_d = S_DONE;
            dbz_d   = 1'b1;
          end else if (op[1]) begin
            state_d = S_DIV;
            acc_d   = {{WIDTH{1'b0}}, mag_a_s};
            opnd_d  = mag_b_s;
          end else begin
            state_d = S_MUL;
            acc_d   = {{WIDTH{1'b0}}, mag_b_s};
            opnd_d  = mag_a_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d = mul_step_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = S_DONE;
          {hi_d, lo_d} = mul_res_s;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        acc_d = div_step_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          lo_d    = neg_res_q ? neg2(div_step_s[WIDTH-1:0]) : div_step_s[WIDTH-1:0];
          hi_d    = neg_rem_q ? neg2(div_step_s[2*WIDTH-1:WIDTH]) : div_step_s[2*WIDTH-1:WIDTH];
        end else begin
          state_d = S_DIV;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, hand-written corner sequences and
// randomized operations checked against a plain-arithmetic reference model.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int           checks = 0, errors = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  typedef struct {
    logic [1:0]   o;
    logic [W-1:0] a, b, eh, el;
  } vec_t;
  vec_t tbl[8];

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: 64-bit arithmetic; SV / and % truncate toward zero with remainder sign of dividend.
  task automatic model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic dbz);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0]        ua, ub, up, uq, ur;
    sa = {{32{av[31]}}, av};
    sb = {{32{bv[31]}}, bv};
    ua = {32'h0, av};
    ub = {32'h0, bv};
    dbz = 1'b0;
    case (o)
      2'b00: begin sp = sa * sb; {m_hi, m_lo} = sp; end
      2'b01: begin up = ua * ub; {m_hi, m_lo} = up; end
      2'b10: if (bv == 32'h0) dbz = 1'b1;
             else begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      default: if (bv == 32'h0) dbz = 1'b1;
               else begin uq = ua / ub; ur = ua % ub; m_lo = uq[31:0]; m_hi = ur[31:0]; end
    endcase
  endtask

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic hw, input logic lw, input logic [W-1:0] wd,
                       output int lat, output logic busy1);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; hi_we = hw; lo_we = lw; wdata = wd;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    busy1 = busy;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string name, input logic [1:0] o, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic hw, input logic lw,
                           input logic [W-1:0] wd, input logic [W-1:0] eh,
                           input logic [W-1:0] el, input logic edbz);
    int   lat;
    logic b1;
    do_op(o, av, bv, hw, lw, wd, lat, b1);
    chk({name, "_lat"}, 64'(lat), edbz ? 64'd1 : 64'd33);
    if (!edbz) chk({name, "_busy_first"}, 64'(b1), 64'd1);
    chk({name, "_hi"}, 64'(hi), 64'(eh));
    chk({name, "_lo"}, 64'(lo), 64'(el));
    chk({name, "_dbz"}, 64'(div_by_zero), 64'(edbz));
    chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({name, "_done_single"}, 64'(done), 64'd0);
    chk({name, "_dbz_clear"}, 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    int           lat, pulses, dlat;
    logic         b1, dbz, hw, lw;
    logic [1:0]   o;
    logic [W-1:0] av, bv, wd, ghi, glo;

    tbl[0] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    tbl[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[5] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[6] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[7] = '{2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};

    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_check($sformatf("tbl%0d", i), tbl[i].o, tbl[i].a, tbl[i].b, 1'b0, 1'b0, 32'h0,
                tbl[i].eh, tbl[i].el, 1'b0);
      m_hi = tbl[i].eh;
      m_lo = tbl[i].el;
    end

    // MTHI/MTLO then divide by zero leaves HI/LO untouched.
    @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk); lo_we = 1'b0;
    chk("mthi", 64'(hi), 64'h1234);
    chk("mtlo", 64'(lo), 64'h5678);
    run_check("divu_by0", 2'b11, 32'd5, 32'd0, 1'b0, 1'b0, 32'h0, 32'h1234, 32'h5678, 1'b1);

    // start and MTHI pulsed while a MULT is busy are both ignored.
    model(2'b00, 32'hFFFF1234, 32'h00005678, dbz);
    @(negedge clk); start = 1'b1; op = 2'b00; a = 32'hFFFF1234; b = 32'h00005678;
    @(negedge clk); start = 1'b0;
    pulses = 0; dlat = 0; ghi = '0; glo = '0;
    for (int n = 1; n <= 45; n++) begin
      if (done) begin pulses++; dlat = n; ghi = hi; glo = lo; end
      if (n == 5) begin
        start = 1'b1; op = 2'b10; a = 32'd77; b = 32'd0; hi_we = 1'b1; wdata = 32'hDEAD;
      end else if (n == 6) begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(negedge clk);
    end
    chk("busy_ign_pulses", 64'(pulses), 64'd1);
    chk("busy_ign_lat", 64'(dlat), 64'd33);
    chk("busy_ign_hi", 64'(ghi), 64'(m_hi));
    chk("busy_ign_lo", 64'(glo), 64'(m_lo));
    chk("busy_ign_hi_final", 64'(hi), 64'(m_hi));

    // Asynchronous reset in busy cycle 10 of a DIV.
    @(negedge clk); start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    run_check("divu_9_3", 2'b11, 32'd9, 32'd3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h3, 1'b0);

    // Randomized ops, some with MTHI/MTLO in the accepting cycle.
    for (int i = 0; i < 40; i++) begin
      o  = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       av = 32'h80000000;
        1:       av = $urandom_range(0, 50);
        default: av = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       bv = 32'h0;
        1:       bv = 32'hFFFFFFFF;
        2:       bv = $urandom_range(1, 9);
        default: bv = $urandom;
      endcase
      hw = ($urandom_range(0, 3) == 0);
      lw = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      if (hw) m_hi = wd;
      if (lw) m_lo = wd;
      model(o, av, bv, dbz);
      run_check($sformatf("rnd%0d", i), o, av, bv, hw, lw, wd, m_hi, m_lo, dbz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit sitting beside the EX-stage ALU in the MIPS pipeline. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the HI/LO registers. The EX stage issues operands over a start/busy/done handshake and stalls while busy is high. The ALU is a single-cycle combinational responder; this block is its multi-cycle, stateful counterpart.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE or DONE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in progress; EX stage must stall
done  output  1  one-cycle pulse: HI/LO hold the new result
div_by_zero  output  1  valid with done; set for DIV/DIVU with b==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=lo=0; busy=done=div_by_zero=0; internal counter and accumulators cleared. Reset mid-operation aborts the operation with no HI/LO update.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE/DONE with start=1:
  - Latch op, |a| and |b| (magnitudes for signed ops, raw values for unsigned), result sign and remainder sign.
  - Go to MUL or DIV and load counter=WIDTH.
  - Exception: DIV/DIVU with b==0 goes straight to DONE with div_by_zero=1 and HI/LO unchanged.
- Otherwise DONE returns to IDLE after 1 cycle. done=1 only in DONE.
- MUL: radix-2 shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
- DIV: restoring division, one quotient bit per cycle.
- Both MUL and DIV decrement the counter each cycle. At counter==1 the next edge enters DONE and writes HI/LO in that same edge.
- Latency: start accepted at edge N → busy=1 for cycles N+1..N+WIDTH → done=1 and HI/LO valid in cycle N+WIDTH+1, busy=0. Divide-by-zero: done in cycle N+1.
- busy=1 exactly in MUL and DIV. start, hi_we and lo_we are ignored while busy.
- Result rules:
  - MULT/MULTU: {hi,lo} = 64-bit product; two's-complement negate when the signed result sign is negative.
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, whose sign follows the dividend.
  - -2^31 / -1 gives lo=0x80000000, hi=0 (no trap).
- MTHI/MTLO: in IDLE or DONE, hi_we/lo_we write wdata into hi/lo at the edge.
- start and hi_we/lo_we in the same accepted cycle: the write occurs, and the operation result later overwrites both registers.
- div_by_zero is cleared on the next start or on leaving DONE.
- done is never asserted in back-to-back cycles unless start is held in DONE. Holding start in DONE is legal and re-issues with the current operands.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 → busy high 32 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after the start edge.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=0x0000000E, hi=0x00000002.
- DIVU a=5, b=0 after MTHI 0x1234 / MTLO 0x5678 → done next cycle with div_by_zero=1; hi=0x1234, lo=0x5678 unchanged.
- During a MULT (busy=1): pulse start (op=DIV) and hi_we with wdata=0xDEAD → both ignored; the MULT result is unchanged and a single done pulse occurs.
- Assert rst_n=0 at busy cycle 10 of a DIV → busy, done and div_by_zero drop immediately, hi=lo=0. A new DIVU 9/3 after release gives lo=3, hi=0.
